// File: rtl/mc_pkg.sv
// Shared encodings and default widths for the PHOLD MC request/response port.
package mc_pkg;
  localparam int MC_RTNCTL_W = 32;
  localparam int MC_DATA_W   = 64;
  localparam int MC_VADR_W   = 48;

  typedef enum logic [2:0] {
    CMD_RD = 3'd1,
    CMD_WR = 3'd2
  } mc_cmd_e;

  typedef enum logic [2:0] {
    RSP_RD_DATA   = 3'd2,
    RSP_WR_CMP    = 3'd3,
    RSP_FLUSH_CMP = 3'd6
  } mc_rsp_cmd_e;

  // Response entry at the default tag width.
  typedef struct packed {
    logic [2:0]             cmd;
    logic [3:0]             scmd;
    logic [MC_RTNCTL_W-1:0] rtnctl;
    logic [MC_DATA_W-1:0]   data;
  } mc_rsp_t;

  localparam int MC_RSP_W = $bits(mc_rsp_t);

  function automatic logic [2:0] mc_rsp_of_cmd(input logic is_rd);
    return is_rd ? RSP_RD_DATA : RSP_WR_CMP;
  endfunction
endpackage

// File: rtl/mc_latency_responder_if.sv
// Request/response bundle of the MC port; master = requester, slave = responder.
interface mc_latency_responder_if
  import mc_pkg::*;
#(
  parameter int MC_RTNCTL_WIDTH = MC_RTNCTL_W
);
  logic                       mc_rq_vld;
  logic [2:0]                 mc_rq_cmd;
  logic [3:0]                 mc_rq_scmd;
  logic [MC_VADR_W-1:0]       mc_rq_vadr;
  logic [1:0]                 mc_rq_size;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic [MC_DATA_W-1:0]       mc_rq_data;
  logic                       mc_rq_flush;
  logic                       mc_rq_stall;
  logic                       mc_rs_vld;
  logic [2:0]                 mc_rs_cmd;
  logic [3:0]                 mc_rs_scmd;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic [MC_DATA_W-1:0]       mc_rs_data;
  logic                       mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl,
           mc_rq_data, mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl,
           mc_rq_data, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );
endinterface

// File: rtl/mc_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; storage is not reset.
module mc_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/mc_latency_responder.sv
// Fixed-latency MC responder: RAM-backed RD/WR/flush with in-order buffered responses.
// Optional MC_STALL_INJECT_EN adds LFSR-driven pseudo-random request stalls.
module mc_latency_responder
  import mc_pkg::*;
#(
  parameter int MC_RTNCTL_WIDTH = MC_RTNCTL_W,
  parameter int RAM_DEPTH       = 1024,
  parameter int LATENCY         = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mc_latency_responder_if.slave  mc,
  output logic                   err_unsup
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  typedef struct packed {
    logic [2:0]                 cmd;
    logic [3:0]                 scmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [MC_DATA_W-1:0]       data;
  } rsp_t;
  localparam int RW = $bits(rsp_t);

  logic                 stall, inj;
  logic                 acc, acc_ok, cmd_rd, cmd_wr, pend_set, flush_in;
  logic [AW-1:0]        idx;
  logic [MC_DATA_W-1:0] ram_q [RAM_DEPTH];
  logic [LATENCY-1:0]   vld_pipe_q;
  rsp_t                 ent_q [LATENCY];
  rsp_t                 ent_d, head;
  logic [CW-1:0]        outst_q, outst_d;
  logic                 pend_q, pend_d, err_q, err_d;
  logic                 rs_vld, f_empty, f_full;
  logic [RW-1:0]        f_dout;
  logic [$clog2(FIFO_DEPTH):0] f_cnt;

`ifdef MC_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
  assign inj = (lfsr_q[1:0] == 2'b00);
`else
  assign inj = 1'b0;
`endif

  // Registered count only: the stall never depends on this cycle's inputs.
  assign stall          = reset || (outst_q >= CW'(FIFO_DEPTH)) || inj;
  assign mc.mc_rq_stall = stall;

  assign idx      = mc.mc_rq_vadr[3 +: AW];
  assign cmd_rd   = (mc.mc_rq_cmd == CMD_RD);
  assign cmd_wr   = (mc.mc_rq_cmd == CMD_WR);
  assign acc      = mc.mc_rq_vld && !stall;
  assign acc_ok   = acc && (cmd_rd || cmd_wr);
  assign pend_set = acc && mc.mc_rq_flush;
  assign flush_in = !stall && !mc.mc_rq_vld && (mc.mc_rq_flush || pend_q);

  always_comb begin
    ent_d = '0;
    if (acc_ok) begin
      ent_d.cmd    = mc_rsp_of_cmd(cmd_rd);
      ent_d.scmd   = mc.mc_rq_scmd;
      ent_d.rtnctl = mc.mc_rq_rtnctl;
      ent_d.data   = cmd_rd ? ram_q[idx] : '0;
    end else if (flush_in) begin
      ent_d.cmd = RSP_FLUSH_CMP;
    end
  end

  // A pending flush was already counted when it was parked.
  always_comb begin
    pend_d  = pend_q;
    if (pend_set)      pend_d = 1'b1;
    else if (flush_in) pend_d = 1'b0;
    err_d   = err_q || (acc && !(cmd_rd || cmd_wr));
    outst_d = outst_q + CW'(acc_ok) + CW'(pend_set && !pend_q)
            + CW'(flush_in && !pend_q) - CW'(rs_vld);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < LATENCY; i++) ent_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= acc_ok || flush_in;
      ent_q[0]      <= ent_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        ent_q[i]      <= ent_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_ok && cmd_wr) ram_q[idx] <= mc.mc_rq_data;
  end

  mc_rsp_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (vld_pipe_q[LATENCY-1]),
    .din_i   (ent_q[LATENCY-1]),
    .pop_i   (rs_vld),
    .dout_o  (f_dout),
    .count_o (f_cnt),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign head            = f_dout;
  assign rs_vld          = !f_empty && !mc.mc_rs_stall;
  assign mc.mc_rs_vld    = rs_vld;
  assign mc.mc_rs_cmd    = rs_vld ? head.cmd    : '0;
  assign mc.mc_rs_scmd   = rs_vld ? head.scmd   : '0;
  assign mc.mc_rs_rtnctl = rs_vld ? head.rtnctl : '0;
  assign mc.mc_rs_data   = rs_vld ? head.data   : '0;
  assign err_unsup       = err_q;

  logic unused_ok;
  assign unused_ok = ^{mc.mc_rq_size, mc.mc_rq_vadr[MC_VADR_W-1:3+AW], mc.mc_rq_vadr[2:0],
                       f_full, f_cnt};
endmodule

// File: tb/tb_mc_latency_responder.sv
// Directed bench for mc_latency_responder; random scoreboard run when MC_STALL_INJECT_EN is set.
module tb_mc_latency_responder;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_unsup;
  always #5 clk = ~clk;

  mc_latency_responder_if #(.MC_RTNCTL_WIDTH(32)) mc ();
  mc_latency_responder dut (.clk(clk), .reset(reset), .mc(mc.slave), .err_unsup(err_unsup));

  typedef struct {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [31:0] rtn;
    logic [63:0] data;
    int          cyc;
  } obs_t;

  obs_t rspq[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset && mc.mc_rs_vld)
      rspq.push_back('{mc.mc_rs_cmd, mc.mc_rs_scmd, mc.mc_rs_rtnctl, mc.mc_rs_data, cyc});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the request until accepted; returns just after the accepting edge.
  task automatic issue(input logic v, input logic [2:0] cmd, input logic [47:0] adr,
                       input logic [63:0] d, input logic [31:0] rt, input logic [3:0] sc,
                       input logic fl);
    int n = 0;
    mc.mc_rq_vld = v; mc.mc_rq_cmd = cmd; mc.mc_rq_vadr = adr; mc.mc_rq_data = d;
    mc.mc_rq_rtnctl = rt; mc.mc_rq_scmd = sc; mc.mc_rq_flush = fl;
    @(negedge clk);
    while (mc.mc_rq_stall && n < 200) begin @(posedge clk); #1; @(negedge clk); n++; end
    if (n >= 200) chk("issue_timeout", 64'd1, 64'd0);
    last_acc = cyc;
    @(posedge clk); #1;
    mc.mc_rq_vld = 1'b0; mc.mc_rq_flush = 1'b0;
  endtask

  task automatic get_rsp(output obs_t r);
    int n = 0;
    while (rspq.size() == 0 && n < 60) begin @(posedge clk); #1; n++; end
    if (rspq.size() == 0) begin
      chk("rsp_timeout", 64'd1, 64'd0);
      r = '{3'd0, 4'd0, 32'd0, 64'd0, 0};
    end else r = rspq.pop_front();
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_0000_0101_0101;
  endfunction

  obs_t r;
  int   a, acc_n, bad, n;

  initial begin
    mc.mc_rq_vld = 0; mc.mc_rq_cmd = 0; mc.mc_rq_scmd = 0; mc.mc_rq_vadr = 0;
    mc.mc_rq_size = 0; mc.mc_rq_rtnctl = 0; mc.mc_rq_data = 0; mc.mc_rq_flush = 0;
    mc.mc_rs_stall = 0;
    @(negedge clk);
    chk("rst_rq_stall", 64'(mc.mc_rq_stall), 64'd1);
    chk("rst_rs_vld",   64'(mc.mc_rs_vld),   64'd0);
    chk("rst_err",      64'(err_unsup),      64'd0);
    chk("rst_rs_data",  mc.mc_rs_data,       64'd0);
    @(posedge clk); #1; reset = 1'b0;
    idle(1);
    chk("post_rst_stall", 64'(mc.mc_rq_stall), 64'd0);

    // WR then RD same word; first response LATENCY+1 after accept
    issue(1'b1, CMD_WR, 48'h40, 64'hDEADBEEF_00000001, 32'd7, 4'h5, 1'b0);
    a = last_acc;
    issue(1'b1, CMD_RD, 48'h40, 64'd0, 32'd8, 4'h2, 1'b0);
    get_rsp(r);
    chk("t1_wr_cmd",  64'(r.cmd), 64'(RSP_WR_CMP));
    chk("t1_wr_rtn",  64'(r.rtn), 64'd7);
    chk("t1_wr_scmd", 64'(r.scmd), 64'd5);
    chk("t1_wr_data", r.data, 64'd0);
    chk("t1_lat",     64'(r.cyc - a), 64'd5);
    get_rsp(r);
    chk("t1_rd_cmd",  64'(r.cmd), 64'(RSP_RD_DATA));
    chk("t1_rd_data", r.data, 64'hDEADBEEF_00000001);
    chk("t1_rd_rtn",  64'(r.rtn), 64'd8);
    chk("t1_rd_scmd", 64'(r.scmd), 64'd2);

    // Fill 12 words, then stall responses and hammer reads
    for (int i = 0; i < 12; i++)
      issue(1'b1, CMD_WR, 48'h1000 + 48'(i) * 48'd8, pat(i), 32'(50 + i), 4'h0, 1'b0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      get_rsp(r);
      if (r.cmd !== RSP_WR_CMP || r.rtn !== 32'(50 + i)) bad++;
    end
    chk("t2_wr_cmps", 64'(bad), 64'd0);
    mc.mc_rs_stall = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 20; c++) begin
      mc.mc_rq_vld = 1'b1; mc.mc_rq_cmd = CMD_RD; mc.mc_rq_scmd = 4'h0; mc.mc_rq_flush = 1'b0;
      mc.mc_rq_vadr = 48'h1000 + 48'(acc_n) * 48'd8; mc.mc_rq_rtnctl = 32'(100 + acc_n);
      @(negedge clk); if (!mc.mc_rq_stall) acc_n++;
      @(posedge clk); #1;
    end
    chk("t2_accepted",   64'(acc_n), 64'd8);
    chk("t2_no_rs_vld",  64'(rspq.size()), 64'd0);
    chk("t2_stall_high", 64'(mc.mc_rq_stall), 64'd1);
    mc.mc_rs_stall = 1'b0;
    n = 0;
    while (acc_n < 12 && n < 60) begin
      mc.mc_rq_vld = 1'b1;
      mc.mc_rq_vadr = 48'h1000 + 48'(acc_n) * 48'd8; mc.mc_rq_rtnctl = 32'(100 + acc_n);
      @(negedge clk); if (!mc.mc_rq_stall) acc_n++;
      @(posedge clk); #1; n++;
    end
    mc.mc_rq_vld = 1'b0;
    chk("t2_all_accepted", 64'(acc_n), 64'd12);
    for (int i = 0; i < 12; i++) begin
      get_rsp(r);
      chk($sformatf("t2_rtn%0d", i),  64'(r.rtn), 64'(100 + i));
      chk($sformatf("t2_data%0d", i), r.data, pat(i));
    end

    // RD with flush on the same cycle, then a standalone flush
    issue(1'b1, CMD_RD, 48'h40, 64'd0, 32'd3, 4'h1, 1'b1);
    get_rsp(r);
    a = r.cyc;
    chk("t3_rd_cmd",  64'(r.cmd), 64'(RSP_RD_DATA));
    chk("t3_rd_rtn",  64'(r.rtn), 64'd3);
    chk("t3_rd_data", r.data, 64'hDEADBEEF_00000001);
    get_rsp(r);
    chk("t3_fl_cmd",  64'(r.cmd), 64'(RSP_FLUSH_CMP));
    chk("t3_fl_rtn",  64'(r.rtn), 64'd0);
    chk("t3_fl_scmd", 64'(r.scmd), 64'd0);
    chk("t3_fl_gap",  64'(r.cyc - a), 64'd1);
    idle(2);
    chk("t3_outst", 64'(dut.outst_q), 64'd0);
    issue(1'b0, 3'd0, 48'd0, 64'd0, 32'd0, 4'h0, 1'b1);
    a = last_acc;
    get_rsp(r);
    chk("t3_fl2_cmd", 64'(r.cmd), 64'(RSP_FLUSH_CMP));
    chk("t3_fl2_lat", 64'(r.cyc - a), 64'd5);

    // Word index wrap and unsupported command
    issue(1'b1, CMD_WR, 48'h0, 64'h55, 32'd20, 4'h0, 1'b0);
    issue(1'b1, CMD_RD, 48'h2000, 64'd0, 32'd21, 4'h0, 1'b0);
    get_rsp(r);
    chk("t4_wr_rtn",  64'(r.rtn), 64'd20);
    get_rsp(r);
    chk("t4_rd_rtn",  64'(r.rtn), 64'd21);
    chk("t4_wrap",    r.data, 64'h55);
    chk("t4_err_pre", 64'(err_unsup), 64'd0);
    issue(1'b1, 3'd7, 48'h40, 64'd0, 32'd22, 4'h0, 1'b0);
    idle(10);
    chk("t4_no_rsp", 64'(rspq.size()), 64'd0);
    chk("t4_err",    64'(err_unsup), 64'd1);
    chk("t4_outst",  64'(dut.outst_q), 64'd0);

    // Reset with requests in flight
    issue(1'b1, CMD_WR, 48'h80, 64'hA5A5_5A5A_0F0F_F0F0, 32'd30, 4'h0, 1'b0);
    get_rsp(r);
    chk("t5_wr_cmd", 64'(r.cmd), 64'(RSP_WR_CMP));
    issue(1'b1, CMD_RD, 48'h80, 64'd0, 32'd31, 4'h0, 1'b0);
    issue(1'b1, CMD_RD, 48'h40, 64'd0, 32'd32, 4'h0, 1'b0);
    issue(1'b1, CMD_RD, 48'h0,  64'd0, 32'd33, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rq_stall", 64'(mc.mc_rq_stall), 64'd1);
    chk("t5_rs_vld",   64'(mc.mc_rs_vld), 64'd0);
    chk("t5_err_clr",  64'(err_unsup), 64'd0);
    chk("t5_rs_rtn",   64'(mc.mc_rs_rtnctl), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    idle(15);
    chk("t5_no_stale", 64'(rspq.size()), 64'd0);
    issue(1'b1, CMD_RD, 48'h80, 64'd0, 32'd34, 4'h0, 1'b0);
    get_rsp(r);
    chk("t5_ram_kept", r.data, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("t5_rtn",      64'(r.rtn), 64'd34);

`ifdef MC_STALL_INJECT_EN
    begin
      logic [63:0] mdl [16];
      obs_t        expq[$];
      logic        wr;
      int          w;
      logic [63:0] d;
      for (int i = 0; i < 216; i++) begin
        mc.mc_rs_stall = ($urandom_range(0, 3) == 0);
        wr = (i < 16) || ($urandom_range(0, 1) == 1);
        w  = (i < 16) ? i : int'($urandom_range(0, 15));
        d  = {$urandom, $urandom};
        issue(1'b1, wr ? CMD_WR : CMD_RD, 48'h3000 + 48'(w) * 48'd8, d, 32'(1000 + i),
              4'(i), 1'b0);
        if (wr) begin
          mdl[w] = d;
          expq.push_back('{RSP_WR_CMP, 4'(i), 32'(1000 + i), 64'd0, 0});
        end else expq.push_back('{RSP_RD_DATA, 4'(i), 32'(1000 + i), mdl[w], 0});
      end
      mc.mc_rs_stall = 1'b0;
      n = 0;
      while (rspq.size() < expq.size() && n < 500) begin @(posedge clk); #1; n++; end
      idle(10);
      chk("t6_count", 64'(rspq.size()), 64'(expq.size()));
      while (expq.size() != 0 && rspq.size() != 0) begin
        obs_t e;
        e = expq.pop_front();
        r = rspq.pop_front();
        chk($sformatf("t6_cmd_%0d", e.rtn), 64'(r.cmd), 64'(e.cmd));
        chk($sformatf("t6_rtn_%0d", e.rtn), 64'(r.rtn), 64'(e.rtn));
        chk($sformatf("t6_dat_%0d", e.rtn), r.data, e.data);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach the end, %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
